// File: rtl/counter_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_cfg_pkg
// Description : Shared constants, FSM state type and reset defaults for the
//               serial configuration front end of the programmable counter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_cfg_pkg;

    localparam int unsigned FRAME_BITS_DEFAULT = 16;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_CTRL  = 4'h2;
    localparam logic [3:0] OP_LIMIT = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } cfg_state_t;

    localparam logic       CFG_EN_RST     = 1'b0;
    localparam logic       CFG_UP_RST     = 1'b1;
    localparam logic       CFG_WRAP_RST   = 1'b1;
    localparam logic [7:0] CFG_LIMIT_RST  = 8'hFF;
    localparam logic [7:0] LOAD_VALUE_RST = 8'h00;

    // Readback byte shifted out on miso at the start of every frame.
    function automatic logic [7:0] status_byte(input logic lv, input logic en,
                                               input logic up, input logic wrap);
        return {lv, en, up, wrap, 4'b0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Parameterized-depth single-bit synchronizer for asynchronous
//               pin inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync_q;
    logic [STAGES-1:0] w_sync_d;

    always_comb begin
        w_sync_d = (r_sync_q << 1) | STAGES'(d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q <= {STAGES{RST_VAL}};
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign q = r_sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/counter_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : counter_cfg_loader
// Description : SPI mode-0 frame receiver that decodes LOAD/CTRL/LIMIT frames
//               into a preload handshake and registered counter controls.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_cfg_loader
    import counter_cfg_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       load_valid,
    input  logic       load_ready,
    output logic [7:0] load_value,
    output logic       cfg_en,
    output logic       cfg_up,
    output logic       cfg_wrap,
    output logic [7:0] cfg_limit,
    output logic       frame_err
);

    localparam logic [4:0] c_CNT_MAX  = 5'd31;
    localparam logic [4:0] c_CNT_FULL = 5'(FRAME_BITS);

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    // cs_n synchronizer resets low so a frame in flight at reset is ignored
    // until the pin is seen high again.
    sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sclk),
        .q   (w_sclk_s)
    );

    sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (w_cs_s)
    );

    sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (w_mosi_s)
    );

    cfg_state_t            r_state_q,      w_state_d;
    logic                  r_sclk_prev_q,  w_sclk_prev_d;
    logic                  r_cs_prev_q,    w_cs_prev_d;
    logic [FRAME_BITS-1:0] r_shift_q,      w_shift_d;
    logic [4:0]            r_bit_cnt_q,    w_bit_cnt_d;
    logic [7:0]            r_miso_sr_q,    w_miso_sr_d;
    logic                  r_miso_q,       w_miso_d;
    logic                  r_load_valid_q, w_load_valid_d;
    logic [7:0]            r_load_value_q, w_load_value_d;
    logic                  r_cfg_en_q,     w_cfg_en_d;
    logic                  r_cfg_up_q,     w_cfg_up_d;
    logic                  r_cfg_wrap_q,   w_cfg_wrap_d;
    logic [7:0]            r_cfg_limit_q,  w_cfg_limit_d;
    logic                  r_frame_err_q,  w_frame_err_d;

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_rise;
    logic       w_cs_fall;
    logic [3:0] w_opcode;
    logic [7:0] w_data;
    logic       w_len_ok;
    logic [7:0] w_status;

    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev_q;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev_q;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev_q;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev_q;

    assign w_opcode = r_shift_q[FRAME_BITS-1 -: 4];
    assign w_data   = r_shift_q[7:0];
    assign w_len_ok = (r_bit_cnt_q == c_CNT_FULL);
    assign w_status = status_byte(r_load_valid_q, r_cfg_en_q, r_cfg_up_q, r_cfg_wrap_q);

    always_comb begin
        w_state_d      = r_state_q;
        w_sclk_prev_d  = w_sclk_s;
        w_cs_prev_d    = w_cs_s;
        w_shift_d      = r_shift_q;
        w_bit_cnt_d    = r_bit_cnt_q;
        w_miso_sr_d    = r_miso_sr_q;
        w_miso_d       = r_miso_q;
        // A pending preload is consumed by any cycle with ready high; a
        // committing LOAD below overrides this with the new value.
        w_load_valid_d = r_load_valid_q & ~load_ready;
        w_load_value_d = r_load_value_q;
        w_cfg_en_d     = r_cfg_en_q;
        w_cfg_up_d     = r_cfg_up_q;
        w_cfg_wrap_d   = r_cfg_wrap_q;
        w_cfg_limit_d  = r_cfg_limit_q;
        w_frame_err_d  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_miso_d = 1'b0;
                if (w_cs_s) begin
                    w_state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                w_miso_d = 1'b0;
                if (w_cs_fall) begin
                    w_bit_cnt_d = 5'd0;
                    w_shift_d   = '0;
                    w_miso_d    = w_status[7];
                    w_miso_sr_d = {w_status[6:0], 1'b0};
                    w_state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (w_sclk_rise) begin
                    w_shift_d = {r_shift_q[FRAME_BITS-2:0], w_mosi_s};
                    if (r_bit_cnt_q != c_CNT_MAX) begin
                        w_bit_cnt_d = r_bit_cnt_q + 5'd1;
                    end
                end
                if (w_sclk_fall) begin
                    w_miso_d    = r_miso_sr_q[7];
                    w_miso_sr_d = {r_miso_sr_q[6:0], 1'b0};
                end
                if (w_cs_rise) begin
                    w_state_d = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                w_miso_d  = 1'b0;
                w_state_d = ST_ARMED;
                if (!w_len_ok) begin
                    w_frame_err_d = 1'b1;
                end else begin
                    case (w_opcode)
                        OP_LOAD: begin
                            if (!r_load_valid_q || load_ready) begin
                                w_load_value_d = w_data;
                                w_load_valid_d = 1'b1;
                            end else begin
                                w_frame_err_d = 1'b1;
                            end
                        end
                        OP_CTRL: begin
                            w_cfg_en_d   = w_data[0];
                            w_cfg_up_d   = w_data[1];
                            w_cfg_wrap_d = w_data[2];
                        end
                        OP_LIMIT: begin
                            w_cfg_limit_d = w_data;
                        end
                        default: begin
                            w_frame_err_d = 1'b1;
                        end
                    endcase
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_sclk_prev_q  <= 1'b0;
            r_cs_prev_q    <= 1'b0;
            r_shift_q      <= '0;
            r_bit_cnt_q    <= 5'd0;
            r_miso_sr_q    <= 8'h00;
            r_miso_q       <= 1'b0;
            r_load_valid_q <= 1'b0;
            r_load_value_q <= LOAD_VALUE_RST;
            r_cfg_en_q     <= CFG_EN_RST;
            r_cfg_up_q     <= CFG_UP_RST;
            r_cfg_wrap_q   <= CFG_WRAP_RST;
            r_cfg_limit_q  <= CFG_LIMIT_RST;
            r_frame_err_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_sclk_prev_q  <= w_sclk_prev_d;
            r_cs_prev_q    <= w_cs_prev_d;
            r_shift_q      <= w_shift_d;
            r_bit_cnt_q    <= w_bit_cnt_d;
            r_miso_sr_q    <= w_miso_sr_d;
            r_miso_q       <= w_miso_d;
            r_load_valid_q <= w_load_valid_d;
            r_load_value_q <= w_load_value_d;
            r_cfg_en_q     <= w_cfg_en_d;
            r_cfg_up_q     <= w_cfg_up_d;
            r_cfg_wrap_q   <= w_cfg_wrap_d;
            r_cfg_limit_q  <= w_cfg_limit_d;
            r_frame_err_q  <= w_frame_err_d;
        end
    end

    assign miso       = r_miso_q;
    assign load_valid = r_load_valid_q;
    assign load_value = r_load_value_q;
    assign cfg_en     = r_cfg_en_q;
    assign cfg_up     = r_cfg_up_q;
    assign cfg_wrap   = r_cfg_wrap_q;
    assign cfg_limit  = r_cfg_limit_q;
    assign frame_err  = r_frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_cfg_loader
// Description : Self-checking bench: directed vector table, hand sequences for
//               handshake/reset corners, and randomized frames vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_cfg_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       load_ready = 1'b0;
    logic       miso;
    logic       load_valid;
    logic [7:0] load_value;
    logic       cfg_en;
    logic       cfg_up;
    logic       cfg_wrap;
    logic [7:0] cfg_limit;
    logic       frame_err;

    counter_cfg_loader #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .cfg_en     (cfg_en),
        .cfg_up     (cfg_up),
        .cfg_wrap   (cfg_wrap),
        .cfg_limit  (cfg_limit),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_err = 0;
    int n_xfer = 0;
    logic [7:0] xfer_val = 8'h00;

    always @(negedge clk) if (frame_err === 1'b1) n_err++;
    always @(posedge clk) if (load_valid === 1'b1 && load_ready === 1'b1) begin
        n_xfer++;
        xfer_val = load_value;
    end

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        bit          e_err;
        bit          e_en;
        bit          e_up;
        bit          e_wrap;
        logic [7:0]  e_lim;
        bit          e_lv;
        logic [7:0]  e_val;
    } vec_t;

    vec_t vecs[9];

    bit         m_en, m_up, m_wrap, m_lv;
    logic [7:0] m_lim, m_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one SPI mode-0 frame and returns on the negedge after the commit edge.
    task automatic send_frame(input logic [31:0] val, input int nbits, input bit rdy_commit,
                              input int rst_at, output logic [7:0] miso_byte);
        miso_byte = 8'h00;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            mosi = val[nbits-1-i];
            repeat (6) @(negedge clk);
            if (i < 8) miso_byte[7-i] = miso;
            sclk = 1'b1;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        load_ready = rdy_commit;
        @(posedge clk);
        @(negedge clk);
        load_ready = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int err0, input bit e_err,
                              input bit e_en, input bit e_up, input bit e_wrap,
                              input logic [7:0] e_lim, input bit e_lv, input logic [7:0] e_val);
        chk({tag, ".en"},    cfg_en,     e_en);
        chk({tag, ".up"},    cfg_up,     e_up);
        chk({tag, ".wrap"},  cfg_wrap,   e_wrap);
        chk({tag, ".limit"}, cfg_limit,  e_lim);
        chk({tag, ".lv"},    load_valid, e_lv);
        chk({tag, ".value"}, load_value, e_val);
        @(negedge clk);
        chk({tag, ".err"}, n_err - err0, e_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mb;
        int         e0, x0;

        vecs[0] = '{32'h2007,   16, 0, 1, 1, 1, 8'hFF, 0, 8'h00};
        vecs[1] = '{32'h30C8,   16, 0, 1, 1, 1, 8'hC8, 0, 8'h00};
        vecs[2] = '{32'h105A,   16, 0, 1, 1, 1, 8'hC8, 1, 8'h5A};
        vecs[3] = '{32'h10A5,   16, 1, 1, 1, 1, 8'hC8, 1, 8'h5A};
        vecs[4] = '{32'h2006,   15, 1, 1, 1, 1, 8'hC8, 1, 8'h5A};
        vecs[5] = '{32'h12006,  17, 1, 1, 1, 1, 8'hC8, 1, 8'h5A};
        vecs[6] = '{32'h7123,   16, 1, 1, 1, 1, 8'hC8, 1, 8'h5A};
        vecs[7] = '{32'h2F02,   16, 0, 0, 1, 0, 8'hC8, 1, 8'h5A};
        vecs[8] = '{32'h3000,   16, 0, 0, 1, 0, 8'h00, 1, 8'h5A};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset.miso", miso, 1'b0);
        check_outs("reset", 0, 0, 0, 1, 1, 8'hFF, 0, 8'h00);

        for (int k = 0; k < 9; k++) begin
            e0 = n_err;
            send_frame(vecs[k].frame, vecs[k].nbits, 1'b0, -1, mb);
            check_outs($sformatf("vec%0d", k), e0, vecs[k].e_err, vecs[k].e_en, vecs[k].e_up,
                       vecs[k].e_wrap, vecs[k].e_lim, vecs[k].e_lv, vecs[k].e_val);
        end

        // One-cycle ready pulse consumes the pending 0x5A.
        x0 = n_xfer;
        load_ready = 1'b1;
        @(negedge clk);
        load_ready = 1'b0;
        chk("hs.lv_drop", load_valid, 1'b0);
        chk("hs.xfer_cnt", n_xfer - x0, 1);
        chk("hs.xfer_val", xfer_val, 8'h5A);

        // LOAD committing in the same cycle as a transfer.
        e0 = n_err;
        send_frame(32'h1011, 16, 1'b0, -1, mb);
        check_outs("reload.first", e0, 0, 0, 1, 0, 8'h00, 1, 8'h11);
        e0 = n_err;
        x0 = n_xfer;
        send_frame(32'h1022, 16, 1'b1, -1, mb);
        check_outs("reload.second", e0, 0, 0, 1, 0, 8'h00, 1, 8'h22);
        chk("reload.xfer_cnt", n_xfer - x0, 1);
        chk("reload.xfer_val", xfer_val, 8'h11);

        // Reset after 8 bits with cs_n still low: the rest of the frame is ignored.
        e0 = n_err;
        send_frame(32'h3012, 16, 1'b0, 8, mb);
        check_outs("midrst", e0, 0, 0, 1, 1, 8'hFF, 0, 8'h00);

        e0 = n_err;
        send_frame(32'h2003, 16, 1'b0, -1, mb);
        check_outs("after_rst.ctrl", e0, 0, 1, 1, 0, 8'hFF, 0, 8'h00);

        e0 = n_err;
        send_frame(32'h3055, 16, 1'b0, -1, mb);
        chk("miso.status", mb, 8'b0110_0000);
        check_outs("after_rst.limit", e0, 0, 1, 1, 0, 8'h55, 0, 8'h00);

        m_en = 1'b1; m_up = 1'b1; m_wrap = 1'b0; m_lim = 8'h55; m_lv = 1'b0; m_val = 8'h00;
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  op;
            logic [7:0]  data;
            logic [15:0] word;
            logic [31:0] fv;
            logic [7:0]  e_miso;
            int          nb;
            bit          rdy, e_err, loaded;

            case ($urandom_range(0, 5))
                0, 1, 5: op = 4'h1;
                2:       op = 4'h2;
                3:       op = 4'h3;
                default: op = 4'($urandom_range(0, 15));
            endcase
            data = 8'($urandom_range(0, 255));
            word = {op, 4'($urandom_range(0, 15)), data};
            case ($urandom_range(0, 9))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            fv = {15'd0, 1'($urandom_range(0, 1)), word};
            rdy = ($urandom_range(0, 3) == 0);

            e_miso = {m_lv, m_en, m_up, m_wrap, 4'b0000};
            e_err  = 1'b0;
            loaded = 1'b0;
            if (nb != 16) begin
                e_err = 1'b1;
            end else if (op == 4'h1) begin
                if (!m_lv || rdy) begin
                    m_val  = data;
                    loaded = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end else if (op == 4'h2) begin
                m_en = data[0]; m_up = data[1]; m_wrap = data[2];
            end else if (op == 4'h3) begin
                m_lim = data;
            end else begin
                e_err = 1'b1;
            end
            m_lv = loaded ? 1'b1 : (m_lv & ~rdy);

            e0 = n_err;
            send_frame(fv, nb, rdy, -1, mb);
            chk($sformatf("rnd%0d.miso", k), mb, e_miso);
            check_outs($sformatf("rnd%0d", k), e0, e_err, m_en, m_up, m_wrap, m_lim, m_lv, m_val);

            if ($urandom_range(0, 2) == 0) begin
                load_ready = 1'b1;
                @(negedge clk);
                load_ready = 1'b0;
                m_lv = 1'b0;
                chk($sformatf("rnd%0d.drain", k), load_valid, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_cfg_loader.md
# counter_cfg_loader

Serial configuration front end for the 8-bit programmable counter. It receives 16-bit SPI-mode-0 frames on three dedicated input pins, decodes them into a preload value and control bits, and drives the counter core. Preloads go to the core over a valid/ready handshake. Control bits and the limit are held as registered levels. It sits directly upstream of the counter in the top-level wrapper.

## Interface
- `FRAME_BITS`, default 16: bits per valid frame.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs_n` and `mosi`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  in  1  serial clock, asynchronous to `clk`; high and low phases each ≥ 2 `clk` periods.
- `cs_n`  in  1  frame select, active low, asynchronous.
- `mosi`  in  1  serial data, MSB first, sampled on rising `sclk`.
- `miso`  out  1  status readback, changes on falling `sclk`.
- `load_valid`  out  1  preload pending.
- `load_ready`  in  1  counter accepts the preload.
- `load_value`  out  8  preload value, stable while `load_valid` is high.
- `cfg_en`  out  1  count enable.
- `cfg_up`  out  1  direction; 1 = up.
- `cfg_wrap`  out  1  1 = wrap at the limit, 0 = saturate.
- `cfg_limit`  out  8  terminal count.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Frame layout: [15:12] opcode, [11:8] reserved (ignored), [7:0] data.
- Opcodes:
  - 0x1 LOAD.
  - 0x2 CTRL: data[0] = en, data[1] = up, data[2] = wrap.
  - 0x3 LIMIT.
  - Any other opcode is rejected.
- FSM states:
  - IDLE: wait until synchronized `cs_n` is high, then go to ARMED.
  - ARMED: on `cs_n` falling, clear the bit counter, capture the status byte and go to SHIFT.
  - SHIFT: shift `mosi` in on each synchronized `sclk` rising edge. On `cs_n` rising, go to COMMIT.
  - COMMIT: execute or reject the frame (one cycle), then go to ARMED.
- Commit rule: execute only if exactly `FRAME_BITS` rising edges were seen. Fewer or more edges means reject with `frame_err` and no state change. The bit counter saturates at 31.
- LOAD:
  - If `load_valid` is low, or `load_ready` is high in the commit cycle: set `load_value` = data and `load_valid` = 1.
  - Otherwise reject with `frame_err`; the pending value is kept.
- Handshake: the transfer occurs on any cycle where `load_valid` and `load_ready` are both high. `load_valid` clears on the next edge unless a LOAD commits in that same cycle, in which case it stays high with the new value.
- `miso`:
  - Status byte captured at frame start: {load_valid, cfg_en, cfg_up, cfg_wrap, 4'b0000}, shifted MSB first.
  - Bit 7 is driven from the start of SHIFT. Each following bit is driven on synchronized `sclk` falling.
  - After 8 bits, `miso` is 0.
- Reset mid-frame: the frame is discarded and the FSM enters IDLE. If `cs_n` is still low, everything is ignored until `cs_n` goes high.

## Timing
- Reset values: `load_valid` 0, `load_value` 0x00, `cfg_en` 0, `cfg_up` 1, `cfg_wrap` 1, `cfg_limit` 0xFF, `frame_err` 0, `miso` 0, FSM IDLE.
- Edge detection compares the last two synchronized samples. A pin edge is recognized `SYNC_STAGES` + 1 cycles after it occurs.
- Commit latency: all outputs (`frame_err`, `load_valid`, `load_value`, `cfg_*`) update on the `clk` edge ending the COMMIT cycle. That is at most `SYNC_STAGES` + 2 = 4 cycles after the `cs_n` rising edge at the pin.
- `mosi` is sampled from its synchronized copy in the cycle the `sclk` rising edge is detected. Setup is guaranteed by the minimum `sclk` phase of 2 cycles.
- `load_value` never changes while `load_valid` = 1, except at a same-cycle transfer-and-reload.
- Back-to-back frames: `cs_n` may fall again 1 `sclk` phase after rising. Because COMMIT lasts one cycle, no frame is lost.

## Structure
- Package `counter_cfg_pkg`:
  - opcode constants `OP_LOAD`, `OP_CTRL`, `OP_LIMIT`
  - `FRAME_BITS` default
  - FSM state enum `cfg_state_t` (IDLE, ARMED, SHIFT, COMMIT)
  - reset-default constants for the cfg outputs.
- Sub-module `sync_2ff`: a parameterized-depth synchronizer, instantiated three times. Everything else (shifter, bit counter, FSM, handshake) stays in `counter_cfg_loader`.

## Test plan
- Reset, then idle 10 cycles: all outputs at their reset values and `frame_err` never pulses.
- CTRL frame 0x2007 → `cfg_en` = 1, `cfg_up` = 1, `cfg_wrap` = 1 within 4 cycles of `cs_n` rising. Then LIMIT 0x30C8 → `cfg_limit` = 0xC8.
- LOAD 0x105A with `load_ready` held low:
  - `load_valid` = 1 and `load_value` = 0x5A.
  - A second LOAD 0x10A5 pulses `frame_err` and the value stays 0x5A.
  - Raise `load_ready` for one cycle: `load_valid` drops on the next edge.
- LOAD commit in the same cycle as `load_ready` = 1 → the old value transfers, `load_valid` stays 1 and `load_value` becomes the new data.
- Framing errors:
  - A 15-bit frame and a 17-bit frame each pulse `frame_err` once and leave the cfg outputs unchanged.
  - Opcode 0x7 is rejected the same way.
- Assert `rst` after 8 bits of a frame with `cs_n` held low, then finish the clocks → the frame is ignored. The next full frame is accepted. `miso` on a frame after CTRL 0x2003 reads 0b0110_0000.
